// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: prescaled period counter, double-buffered duties loaded at wrap.
// Define PWM_BANK_PHASE_EN to stagger each channel's phase by k*STEP ticks.
module pwm_bank #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8,
  localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [CHAN_W-1:0]     i_wr_chan,
  input  logic [WIDTH-1:0]      i_wr_duty,
  output logic                  o_wr_err,
  output logic [CHANNELS-1:0]   o_pwm,
  output logic                  o_period_strobe
);
  localparam int PERIOD = (1 << WIDTH) - 1;
  localparam logic [WIDTH-1:0] MAX = WIDTH'(PERIOD - 1);
  localparam logic [CHAN_W:0] NCHAN = (CHAN_W + 1)'(CHANNELS);

  logic [PRESCALE_W-1:0] pre_p0;
  logic [WIDTH-1:0]      cnt_p0;
  logic [WIDTH-1:0]      shadow [CHANNELS];
  logic [WIDTH-1:0]      active [CHANNELS];
  logic                  rdy_p0;
  logic                  wrap_p1;
  logic                  tick;
  logic                  wrap;
  logic                  accept;
  logic                  chan_ok;
  logic [CHANNELS-1:0]   pwm_next;

`ifdef PWM_BANK_PHASE_EN
  localparam int STEP = PERIOD / CHANNELS;

  function automatic logic [WIDTH-1:0] phase_of(input int k, input logic [WIDTH-1:0] c);
    logic [WIDTH:0] sum;
    sum = {1'b0, c} + (WIDTH + 1)'(PERIOD - k * STEP);
    if (sum >= (WIDTH + 1)'(PERIOD)) sum = sum - (WIDTH + 1)'(PERIOD);
    return sum[WIDTH-1:0];
  endfunction
`endif

  // A prescale value dropped below the running count forces an immediate tick.
  assign tick       = (pre_p0 >= i_prescale);
  assign wrap       = i_enable && tick && (cnt_p0 == MAX);
  assign o_wr_ready = rdy_p0 && !wrap;
  assign accept     = i_wr_valid && o_wr_ready;
  assign chan_ok    = ({1'b0, i_wr_chan} < NCHAN);

  always_comb begin
    pwm_next = '0;
    for (int k = 0; k < CHANNELS; k++) begin
`ifdef PWM_BANK_PHASE_EN
      pwm_next[k] = i_enable && (phase_of(k, cnt_p0) < active[k]);
`else
      pwm_next[k] = i_enable && (cnt_p0 < active[k]);
`endif
    end
  end

  // stage p0: prescaler, period counter, duty registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_p0 <= '0;
      cnt_p0 <= '0;
      rdy_p0 <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      rdy_p0 <= 1'b1;
      if (!i_enable) begin
        pre_p0 <= '0;
        cnt_p0 <= '0;
      end else if (tick) begin
        pre_p0 <= '0;
        cnt_p0 <= (cnt_p0 == MAX) ? '0 : cnt_p0 + WIDTH'(1);
      end else begin
        pre_p0 <= pre_p0 + PRESCALE_W'(1);
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (!i_enable || wrap) active[k] <= shadow[k];
        if (accept && chan_ok && (i_wr_chan == CHAN_W'(k))) shadow[k] <= i_wr_duty;
      end
    end
  end

  // stage p1: registered compare; strobe delayed one more cycle to line up with new-period output
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pwm           <= '0;
      o_wr_err        <= 1'b0;
      wrap_p1         <= 1'b0;
      o_period_strobe <= 1'b0;
    end else begin
      o_pwm           <= pwm_next;
      o_wr_err        <= accept && !chan_ok;
      wrap_p1         <= wrap;
      o_period_strobe <= wrap_p1 && i_enable;
    end
  end
endmodule

// File: doc/pwm_bank.md
# pwm_bank

Parametrised multi-channel PWM generator, successor to the fixed three-output PWM block in the top-level design. Generalises channel count and resolution, adds a clock prescaler, per-channel double-buffered duty registers loaded through a valid/ready write port (fed by the SPI register decoder), and glitch-free updates at period boundaries. It sits between the SPI command decoder and the motor/LED drive pins.

## Interface
- CHANNELS, 4, number of PWM outputs (1..16)
- WIDTH, 8, duty/counter resolution in bits (2..16); period = 2^WIDTH-1 ticks
- PRESCALE_W, 8, width of prescaler input
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  run counters; low = hold and outputs low
- i_prescale  in  PRESCALE_W  tick every i_prescale+1 clocks; sampled every cycle
- i_wr_valid  in  1  duty write request
- o_wr_ready  out  1  write can be accepted this cycle
- i_wr_chan  in  clog2(CHANNELS) (min 1)  target channel
- i_wr_duty  in  WIDTH  new duty value
- o_wr_err  out  1  one-cycle pulse: accepted write had i_wr_chan >= CHANNELS
- o_pwm  out  CHANNELS  PWM outputs, registered
- o_period_strobe  out  1  one-cycle pulse when active duties load

## Operation
- Prescaler: counts 0..i_prescale; tick asserted in cycle where count == i_prescale, then count returns to 0. If i_prescale changes below current count, count wraps to 0 next cycle (tick asserted).
- Period counter cnt: advances on tick, 0..MAX where MAX = 2^WIDTH-2, wraps to 0. Wrap event = tick with cnt == MAX.
- Compare: o_pwm[k] next = (cnt < active[k]). duty 0 -> always low; duty 2^WIDTH-1 -> always high; otherwise high for exactly duty ticks per period.
- Write: accepted when i_wr_valid && o_wr_ready. Valid chan -> shadow[chan] <= i_wr_duty. Invalid chan -> no register change, o_wr_err pulses next cycle. Multiple writes per period: last wins.
- Update: on wrap event all active[k] <= shadow[k] simultaneously; o_period_strobe pulses. o_wr_ready is low exactly in the wrap-event cycle (no shadow/active collision); high otherwise after reset.
- Disabled (i_enable low): prescaler and cnt held at 0, o_pwm all 0, active[k] tracks shadow[k] every cycle, writes still accepted, o_wr_ready high, no strobe. On re-enable, counting starts from cnt=0 with latest duties.

## Timing
- Reset (async assert, sync release): all shadow/active = 0, cnt = 0, prescaler = 0, o_pwm = 0, o_wr_ready = 0, o_wr_err = 0, o_period_strobe = 0. o_wr_ready rises first clock after release.
- o_pwm lags cnt by one clock (registered compare).
- Write accepted at edge t: shadow valid after t; earliest effect on o_pwm is one clock after next wrap event.
- o_period_strobe registered: high the cycle after wrap edge, aligned with first o_pwm of new period.
- Reset mid-period: outputs drop immediately (async); pending shadow contents lost.
- Simultaneous i_enable fall and wrap: disable wins; no strobe; active tracks shadow.

## Configuration
- PWM_BANK_PHASE_EN defined: channel k uses phase-shifted count ph_k = (cnt + (MAX+1) - k*STEP) mod (MAX+1), STEP = (2^WIDTH-1)/CHANNELS (integer); o_pwm[k] = (ph_k < active[k]). Spreads rising edges to reduce supply current peaks. Duty per period unchanged.
- Not defined: all channels compare against cnt directly; all rising edges align at cnt = 0. No phase logic synthesised.

## Test plan
- WIDTH=4, CHANNELS=4, prescale 0, enable; write ch0 duty 5 -> after next strobe, o_pwm[0] high 5 / low 10 cycles, strobe every 15 cycles.
- Write ch1 duty 0, ch2 duty 15 -> o_pwm[1] constant 0, o_pwm[2] constant 1 across three periods, no glitches at wrap.
- Mid-period write ch3 duty 3 then duty 10 -> active value changes only at next strobe; o_pwm[3] shows 10 high cycles, never 3; o_wr_ready low only in wrap cycle.
- prescale 2 -> strobe every 45 cycles; write chan 5 (CHANNELS=4, chan width 2 -> use CHANNELS=5 with chan 6) -> o_wr_err one pulse, no duty change.
- Assert i_rst_n low mid-period with o_pwm[0] high -> o_pwm, strobe, o_wr_ready 0 without clock edge; after release duties read 0.
- PWM_BANK_PHASE_EN, all duties 7 -> o_pwm[1] rises 3 ticks after o_pwm[0], o_pwm[3] 9 ticks after, each high 7 ticks.
